// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch front end.
//   fetch_state_e    : RUN while fetching, HALT after a fault reaches the queue
//   fq_entry_t       : one fetch-queue entry {pc, inst, err}
//   RESET_PC_DEFAULT : first fetched address after reset
//   is_word_aligned  : true when the two low address bits are zero
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_1000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  // Entry fields follow the package word width; the fetch unit is built at 32 bits.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] inst;
    logic                    err;
  } fq_entry_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lo);
    return addr_lo == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the fetch unit's bus-facing signals.
//   imem_req_*  : word read request toward instruction memory
//   imem_resp_* : in-order read response (data plus access-fault flag)
//   redirect_*  : taken branch/jump pulse and its target
//   dec_*       : fetch-queue head presented to Decode with valid/ready
// The master modport is the fetch unit; slave is the memory/decode side.
interface fetch_unit_if import fetch_pkg::*; #(parameter int XLEN = XLEN_DEFAULT);

  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_resp_valid;
  logic [XLEN-1:0] imem_resp_data;
  logic            imem_resp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [XLEN-1:0] dec_inst;
  logic [XLEN-1:0] dec_pc;
  logic            dec_err;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid, imem_resp_data, imem_resp_err,
    input  redirect_valid, redirect_pc,
    output dec_valid, dec_inst, dec_pc, dec_err,
    input  dec_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid, imem_resp_data, imem_resp_err,
    output redirect_valid, redirect_pc,
    input  dec_valid, dec_inst, dec_pc, dec_err,
    output dec_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry synchronous FIFO of fetch-queue entries.
//   clk, rst     : clock, synchronous active-high reset
//   flush_i      : empty the FIFO; a same-cycle push lands as the sole entry
//   push_i       : write push_data_i (caller guarantees no overflow)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : head entry, read combinationally
//   empty_o      : no entries held
//   count_o      : number of entries held
module fetch_fifo import fetch_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  fq_entry_t              push_data_i,
  input  logic                   pop_i,
  output fq_entry_t              head_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  fq_entry_t         mem_q [DEPTH];
  logic [PW-1:0]     rd_ptr_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_pop;
  logic [PW-1:0]     wr_idx;

  assign do_pop  = pop_i && (count_q != '0);
  assign wr_idx  = flush_i ? '0 : wr_ptr_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally. A flush restarts both pointers at slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= push_i ? PW'(1) : '0;
      count_q  <= push_i ? CW'(1) : '0;
    end else begin
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(do_pop);
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_idx] <= push_data_i;
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end.
//   clk, rst    : clock, synchronous active-high reset
//   bus         : fetch_unit_if.master (imem request/response, redirect, decode)
//   halted      : fetch stopped on a fault
//   fetch_count : instructions handed to Decode (wraps)
//   last_pc     : pc of the most recently delivered instruction
//   last_inst   : most recently delivered instruction word
// A credit rule (queued + in-flight < FQ_DEPTH) bounds outstanding requests so
// every response has a queue slot. Responses for requests issued before a
// redirect are counted off by a drop counter and discarded.
module fetch_unit import fetch_pkg::*; #(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              FQ_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  fetch_unit_if.master     bus,
  output logic             halted,
  output logic [31:0]      fetch_count,
  output logic [XLEN-1:0]  last_pc,
  output logic [XLEN-1:0]  last_inst
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW + 1)'(FQ_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [31:0]     fetch_count_q;
  logic [XLEN-1:0] last_pc_q, last_inst_q;

  logic            fifo_flush, fifo_push, fifo_pop, fifo_empty;
  fq_entry_t       fifo_wdata, fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            credit_ok, req_fire;

  fetch_fifo #(.DEPTH(FQ_DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (fifo_flush),
    .push_i      (fifo_push),
    .push_data_i (fifo_wdata),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  // Request issue is blocked during reset, while halted, in a redirect cycle,
  // and whenever the queue could not absorb one more response.
  assign credit_ok          = ({1'b0, fifo_count} + {1'b0, inflight_q}) < DEPTH_LIM;
  assign bus.imem_req_valid = !rst && (state_q == RUN) && !bus.redirect_valid && credit_ok;
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;

  assign bus.dec_valid = !fifo_empty;
  assign bus.dec_pc    = bus.dec_valid ? fifo_head.pc   : '0;
  assign bus.dec_inst  = bus.dec_valid ? fifo_head.inst : '0;
  assign bus.dec_err   = bus.dec_valid && fifo_head.err;
  assign fifo_pop      = bus.dec_valid && bus.dec_ready;

  assign halted      = (state_q == HALT);
  assign fetch_count = fetch_count_q;
  assign last_pc     = last_pc_q;
  assign last_inst   = last_inst_q;

  // Next-state logic. A redirect overrides everything else in its cycle: the
  // queue is flushed, this cycle's response is consumed without enqueueing,
  // and whatever is still in flight afterwards becomes the drop count. A
  // misaligned target is reported as a single faulting entry.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    fifo_wdata = '0;
    inflight_d = inflight_q + CW'(req_fire) - CW'(bus.imem_resp_valid);

    if (bus.redirect_valid) begin
      fifo_flush = 1'b1;
      pc_d       = bus.redirect_pc;
      resp_pc_d  = bus.redirect_pc;
      drop_d     = inflight_d;
      state_d    = RUN;
      if (!is_word_aligned(bus.redirect_pc[1:0])) begin
        fifo_push  = 1'b1;
        fifo_wdata = '{pc: bus.redirect_pc, inst: '0, err: 1'b1};
        state_d    = HALT;
      end
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (bus.imem_resp_valid) begin
        if (drop_q != '0) begin
          drop_d = drop_q - 1'b1;
        end else if (state_q == RUN) begin
          fifo_push  = 1'b1;
          fifo_wdata = '{pc: resp_pc_q, inst: bus.imem_resp_data, err: bus.imem_resp_err};
          resp_pc_d  = resp_pc_q + XLEN'(4);
          if (bus.imem_resp_err) state_d = HALT;
        end
      end
    end
  end

  // State registers plus the delivery counters, which only move on a
  // Decode handshake (a handshake in a redirect cycle still counts).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      inflight_q    <= '0;
      drop_q        <= '0;
      fetch_count_q <= '0;
      last_pc_q     <= '0;
      last_inst_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      if (fifo_pop) begin
        fetch_count_q <= fetch_count_q + 32'd1;
        last_pc_q     <= fifo_head.pc;
        last_inst_q   <= fifo_head.inst;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// A latency-programmable memory answers requests in order; a queue-based model
// of the fetch behaviour is checked against the DUT every cycle, and directed
// scenarios pin key values with hand-computed literals.
module tb_fetch_unit;

  localparam logic [31:0] NO_ERR = 32'hFFFF_FFFC;

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic err; } mEntry_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  logic        clk;
  logic        rst;
  logic        halted;
  logic [31:0] fetchCount, lastPc, lastInst;

  fetch_unit_if #(.XLEN(32)) bus();

  fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_1000), .FQ_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .halted      (halted),
    .fetch_count (fetchCount),
    .last_pc     (lastPc),
    .last_inst   (lastInst)
  );

  int          checks = 0;
  int          passed = 0;
  int          cycle  = 0;
  int          lat    = 1;
  logic [31:0] errAddr = NO_ERR;
  pend_t       pend[$];

  mEntry_t     mq[$];
  logic [31:0] mPc, mRespPc, mCount, mLastPc, mLastInst;
  int          mInflight, mDrop;
  bit          mHalted;
  bit          synced = 0;

  // Free-running clock and a cycle index used by the memory for latency.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cycle = cycle + 1;
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    return 32'h2400_0000 ^ {a[15:0], a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic memReady, input logic decReady,
                               input logic redir, input logic [31:0] redirPc);
    bus.imem_req_ready = memReady;
    bus.dec_ready      = decReady;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redirPc;
  endtask

  task automatic redirectTo(input logic [31:0] target);
    nextCycle();
    applyStimulus(bus.imem_req_ready, bus.dec_ready, 1'b1, target);
    nextCycle();
    applyStimulus(bus.imem_req_ready, bus.dec_ready, 1'b0, 32'h0);
  endtask

  task automatic waitDecValid(input int budget);
    int n = 0;
    peek();
    while (!bus.dec_valid && n < budget) begin
      nextCycle();
      peek();
      n++;
    end
    checkBit("wait_dec_valid", bus.dec_valid, 1'b1);
  endtask

  // Instruction memory: records accepted requests mid-cycle and returns each
  // one 'lat' cycles later, in order, one per cycle. Reset cancels pending reads.
  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = '0;
    bus.imem_resp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (bus.imem_req_valid && bus.imem_req_ready)
        pend.push_back('{bus.imem_req_addr, cycle + lat});
      @(posedge clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cycle) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = memData(pend[0].addr);
        bus.imem_resp_err   = (pend[0].addr == errAddr);
        void'(pend.pop_front());
      end else begin
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.imem_resp_err   = 1'b0;
      end
    end
  end

  // Compare process: every mid-cycle, checks the DUT against the model, then
  // advances the model by what the coming clock edge will do.
  initial begin
    bit expReq, decFire, reqFire;
    forever begin
      @(negedge clk);
      expReq = !rst && !mHalted && !bus.redirect_valid && (mq.size() + mInflight < 4);
      if (synced) begin
        checkBit("req_valid", bus.imem_req_valid, expReq);
        if (expReq) checkOutput("req_addr", bus.imem_req_addr, mPc);
        checkBit("dec_valid", bus.dec_valid, mq.size() > 0);
        if (mq.size() > 0) begin
          checkOutput("dec_pc", bus.dec_pc, mq[0].pc);
          checkOutput("dec_inst", bus.dec_inst, mq[0].inst);
          checkBit("dec_err", bus.dec_err, mq[0].err);
        end
        checkBit("halted", halted, mHalted);
        checkOutput("fetch_count", fetchCount, mCount);
        checkOutput("last_pc", lastPc, mLastPc);
        checkOutput("last_inst", lastInst, mLastInst);
      end
      if (rst) begin
        mq.delete();
        mPc = 32'h1000; mRespPc = 32'h1000;
        mInflight = 0; mDrop = 0; mHalted = 0;
        mCount = 0; mLastPc = 0; mLastInst = 0;
        synced = 1;
      end else if (synced) begin
        decFire = (mq.size() > 0) && bus.dec_ready;
        reqFire = expReq && bus.imem_req_ready;
        if (decFire) begin
          mCount    = mCount + 1;
          mLastPc   = mq[0].pc;
          mLastInst = mq[0].inst;
          void'(mq.pop_front());
        end
        if (bus.imem_resp_valid) mInflight--;
        if (bus.redirect_valid) begin
          mq.delete();
          mDrop   = mInflight;
          mPc     = bus.redirect_pc;
          mRespPc = bus.redirect_pc;
          mHalted = 0;
          if (bus.redirect_pc[1:0] != 2'b00) begin
            mq.push_back('{bus.redirect_pc, 32'h0, 1'b1});
            mHalted = 1;
          end
        end else begin
          if (reqFire) begin
            mPc = mPc + 4;
            mInflight++;
          end
          if (bus.imem_resp_valid) begin
            if (mDrop > 0) mDrop--;
            else if (!mHalted) begin
              mq.push_back('{mRespPc, bus.imem_resp_data, bus.imem_resp_err});
              mRespPc = mRespPc + 4;
              if (bus.imem_resp_err) mHalted = 1;
            end
          end
        end
      end
    end
  end

  // Directed scenarios with hand-computed expectations.
  initial begin
    rst = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (3) @(posedge clk);
    peek();
    checkBit("rst_req_valid", bus.imem_req_valid, 1'b0);
    checkBit("rst_dec_valid", bus.dec_valid, 1'b0);
    checkOutput("rst_dec_pc", bus.dec_pc, 32'h0);
    checkBit("rst_halted", halted, 1'b0);
    checkOutput("rst_fetch_count", fetchCount, 32'h0);
    checkOutput("rst_last_pc", lastPc, 32'h0);
    checkOutput("rst_last_inst", lastInst, 32'h0);

    // Streaming at 1-cycle latency: pc n is delivered two cycles after issue.
    nextCycle(); rst = 1'b0;
    peek();
    checkBit("first_req_valid", bus.imem_req_valid, 1'b1);
    checkOutput("first_req_addr", bus.imem_req_addr, 32'h1000);
    nextCycle(); nextCycle(); peek();
    checkOutput("first_dec_pc", bus.dec_pc, 32'h1000);
    checkOutput("first_dec_inst", bus.dec_inst, 32'h3400_1000);
    nextCycle(); peek();
    checkOutput("stream_count_1", fetchCount, 32'd1);
    checkOutput("stream_last_pc", lastPc, 32'h1000);
    checkOutput("stream_dec_pc_1", bus.dec_pc, 32'h1004);
    repeat (4) nextCycle();
    peek();
    checkOutput("stream_count_5", fetchCount, 32'd5);
    checkOutput("stream_dec_pc_5", bus.dec_pc, 32'h1014);

    // Decode stall: issue stops once four words are outstanding.
    nextCycle(); applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    repeat (10) nextCycle();
    peek();
    checkBit("stall_req_valid", bus.imem_req_valid, 1'b0);
    checkOutput("stall_dec_pc", bus.dec_pc, 32'h1018);
    checkOutput("stall_next_addr", bus.imem_req_addr, 32'h1028);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (8) nextCycle();

    // 3-cycle latency, redirect with two reads in flight.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (8) nextCycle();
    lat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    nextCycle();
    nextCycle(); applyStimulus(1'b0, 1'b1, 1'b1, 32'h2000);
    peek();
    checkBit("redir_req_blocked", bus.imem_req_valid, 1'b0);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    peek();
    checkOutput("redir_req_addr", bus.imem_req_addr, 32'h2000);
    waitDecValid(20);
    checkOutput("redir_dec_pc", bus.dec_pc, 32'h2000);
    repeat (5) nextCycle();

    // Access fault at 0x1008 halts fetch; a redirect resumes it.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    repeat (8) nextCycle();
    lat = 1;
    errAddr = 32'h1008;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    redirectTo(32'h1000);
    repeat (4) nextCycle();
    peek();
    checkBit("err_halted", halted, 1'b1);
    checkBit("err_dec_err", bus.dec_err, 1'b1);
    checkOutput("err_dec_pc", bus.dec_pc, 32'h1008);
    checkBit("err_req_valid", bus.imem_req_valid, 1'b0);
    repeat (3) nextCycle();
    peek();
    checkBit("halt_req_valid", bus.imem_req_valid, 1'b0);
    errAddr = NO_ERR;
    redirectTo(32'h1000);
    peek();
    checkBit("resume_halted", halted, 1'b0);
    checkOutput("resume_req_addr", bus.imem_req_addr, 32'h1000);
    repeat (2) nextCycle();

    // Misaligned redirect produces a single faulting entry.
    redirectTo(32'h2002);
    peek();
    checkBit("mis_dec_valid", bus.dec_valid, 1'b1);
    checkOutput("mis_dec_pc", bus.dec_pc, 32'h2002);
    checkOutput("mis_dec_inst", bus.dec_inst, 32'h0);
    checkBit("mis_dec_err", bus.dec_err, 1'b1);
    checkBit("mis_halted", halted, 1'b1);
    nextCycle(); peek();
    checkBit("mis_drained", bus.dec_valid, 1'b0);
    checkOutput("mis_last_pc", lastPc, 32'h2002);
    repeat (3) nextCycle();

    // Redirect in the same cycle as a response and a Decode handshake.
    redirectTo(32'h3000);
    repeat (3) nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h4000);
    peek();
    checkOutput("coin_dec_pc", bus.dec_pc, 32'h3004);
    nextCycle(); applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    peek();
    checkBit("coin_empty", bus.dec_valid, 1'b0);
    checkOutput("coin_last_pc", lastPc, 32'h3004);
    checkOutput("coin_req_addr", bus.imem_req_addr, 32'h4000);
    repeat (6) nextCycle();

    // Reset in mid-operation clears everything.
    rst = 1'b1;
    nextCycle(); peek();
    checkOutput("midrst_count", fetchCount, 32'h0);
    checkBit("midrst_dec_valid", bus.dec_valid, 1'b0);
    checkBit("midrst_req_valid", bus.imem_req_valid, 1'b0);
    nextCycle(); rst = 1'b0;
    peek();
    checkOutput("midrst_req_addr", bus.imem_req_addr, 32'h1000);
    repeat (6) nextCycle();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
